imm_gen_stage: RTL
==================

// Module: imm_gen_stage
// PURPOSE
//  Registered RV32I/RV64I immediate-generation stage for the decode path.
//  Accepts instructions on a valid/ready handshake and decodes the opcode into a format code.
//  Emits the sign-/zero-extended immediate, the format code and an illegal flag.
//  Output is buffered in a 2-entry skid buffer, so in_ready never depends combinationally on out_ready.
//  Sits between the fetch register and the ID/EX register; replaces the combinational generator.
// PARAMETERS
//  DATA_WIDTH   32  immediate width; legal values are 32 or 64.
//  TAG_WIDTH    5   sideband tag (PC index / ROB id) carried alongside each instruction.
//  SUPPORT_CSR  1   1: SYSTEM with funct3[2]=1 yields zimm; 0: such encodings are flagged illegal.
// PORTS
//  clk          in   1           clock, all state on rising edge
//  rst          in   1           synchronous reset, active-high
//  flush        in   1           synchronous pipeline flush
//  in_valid     in   1           upstream has an instruction
//  in_ready     out  1           stage can accept; = (state != TWO)
//  in_instr     in   32          raw instruction word
//  in_tag       in   TAG_WIDTH   sideband tag
//  out_valid    out  1           out_* fields are valid
//  out_ready    in   1           downstream accepts
//  out_imm      out  DATA_WIDTH  generated immediate
//  out_fmt      out  3           0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z(csr), 7 illegal
//  out_illegal  out  1           opcode is not decodable
//  out_tag      out  TAG_WIDTH   tag of the output entry
//  illegal_cnt  out  16          count of illegal entries popped; saturating
// BEHAVIOUR
//  Decode uses opcode = instr[6:0]. sext = sign-extend to DATA_WIDTH from the MSB shown.
//   I  (0010011, 0000011, 1100111): sext(instr[31:20]).
//      OP-IMM shifts (0010011, funct3 001/101) zero-extend the shamt field:
//      instr[24:20] when DATA_WIDTH=32, instr[25:20] when DATA_WIDTH=64.
//   S  (0100011): sext({instr[31:25], instr[11:7]}).
//   B  (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
//   U  (0110111, 0010111): sext({instr[31:12], 12'b0}); bit 31 replicated when DATA_WIDTH=64.
//   J  (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
//   Z  (1110011 with funct3[2]=1, SUPPORT_CSR=1): zero-extend instr[19:15].
//   R  (0110011, and 1110011 with funct3[2]=0): imm=0, fmt=0, not illegal.
//   Any other opcode: imm=0, fmt=7, out_illegal=1.
//  Decoding happens on the push path; registered entries hold the decoded fields.
//  Buffer FSM (main = output register, skid = second register); push = in_valid&in_ready, pop = out_valid&out_ready:
//   EMPTY --push--> ONE (load main).
//   ONE: push&pop -> ONE (reload main); push only -> TWO (load skid); pop only -> EMPTY.
//   TWO: pop -> ONE (skid moves to main); push is impossible (in_ready=0).
//  Latency: 1 cycle from push to out_valid. Throughput: 1 per cycle while out_ready=1.
//  out_valid = (state != EMPTY). Output fields stay stable while out_valid & !out_ready.
//  Ordering is strictly FIFO.
//  flush: next state is EMPTY and out_valid=0 on the following cycle.
//   A push in the flush cycle is discarded. illegal_cnt is not cleared by flush.
//   Any pop completing in the flush cycle still counts toward illegal_cnt.
//  illegal_cnt: +1 on each pop with out_illegal=1; holds at 16'hFFFF.
//  rst (wins over flush): state EMPTY; out_valid=0, out_imm=0, out_fmt=0, out_illegal=0,
//   out_tag=0, illegal_cnt=0, skid contents=0. A push in the reset cycle is ignored.
//   in_ready is 1 from the cycle after rst deasserts.
// TESTING
//  1 addi 0xFFF00093, DW=32 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1.
//  2 sw 0xFE112E23 -> out_imm=0xFFFFFFFC, fmt=2. beq 0xFE000CE3 -> out_imm=0xFFFFFFF8, fmt=3.
//  3 lui 0x800002B7, DW=64 -> out_imm=0xFFFFFFFF80000000, fmt=4.
//    slli 0x03F09093, DW=64 -> out_imm=0x3F, fmt=1.
//  4 out_ready=0, push tags 1,2,3 back-to-back -> only 1,2 accepted; in_ready=0 after the 2nd push;
//    out_ready=1 -> tags 1,2 pop in order, then 3 is accepted.
//  5 state TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry surfaces.
//  6 push 0x00000000 then pop -> out_illegal=1, fmt=7, illegal_cnt=1;
//    force illegal_cnt to 0xFFFF, pop another illegal entry -> illegal_cnt stays 0xFFFF.

Source files
------------

// File: rtl/imm_gen_stage.sv
// Registered RV32I/RV64I immediate generator with a 2-entry skid buffer.
// Instructions are decoded on the push path. Each buffer entry holds the decoded
// immediate, the format code, the illegal flag and the sideband tag.
module imm_gen_stage #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TAG_WIDTH   = 5,
    parameter bit          SUPPORT_CSR = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [2:0]            out_fmt,
    output logic                  out_illegal,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [15:0]           illegal_cnt
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_Z   = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] imm;
        logic [2:0]            fmt;
        logic                  illegal;
        logic [TAG_WIDTH-1:0]  tag;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state, state_next;
    entry_t main_q, skid_q, incoming;
    logic   push, pop;

    // Decode one instruction word into immediate / format / illegal (tag left zero).
    function automatic entry_t decode(input logic [31:0] ins);
        entry_t e;
        e = '0;
        case (ins[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                e.fmt = FMT_I;
                if (ins[6:0] == 7'b0010011 && ins[13:12] == 2'b01) begin
                    // shamt: 5 bits on RV32, 6 bits on RV64
                    e.imm = DATA_WIDTH'(ins[24:20]);
                    if (DATA_WIDTH == 64) e.imm[5] = ins[25];
                end else begin
                    e.imm = DATA_WIDTH'($signed(ins[31:20]));
                end
            end
            7'b0100011: begin
                e.fmt = FMT_S;
                e.imm = DATA_WIDTH'($signed({ins[31:25], ins[11:7]}));
            end
            7'b1100011: begin
                e.fmt = FMT_B;
                e.imm = DATA_WIDTH'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                e.fmt = FMT_U;
                e.imm = DATA_WIDTH'($signed({ins[31:12], 12'b0}));
            end
            7'b1101111: begin
                e.fmt = FMT_J;
                e.imm = DATA_WIDTH'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            7'b1110011: begin
                if (!ins[14]) begin
                    e.fmt = FMT_R;
                end else if (SUPPORT_CSR) begin
                    e.fmt = FMT_Z;
                    e.imm = DATA_WIDTH'(ins[19:15]);
                end else begin
                    e.fmt     = FMT_ILL;
                    e.illegal = 1'b1;
                end
            end
            7'b0110011: e.fmt = FMT_R;
            default: begin
                e.fmt     = FMT_ILL;
                e.illegal = 1'b1;
            end
        endcase
        return e;
    endfunction

    assign in_ready    = (state != TWO);
    assign out_valid   = (state != EMPTY);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_tag     = main_q.tag;

    // Decode the incoming instruction and attach its tag.
    always_comb begin
        incoming     = decode(in_instr);
        incoming.tag = in_tag;
    end

    // Next-state logic for the skid buffer occupancy.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)      state_next = TWO;
                else if (!push && pop) state_next = EMPTY;
            end
            TWO:   if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
        if (flush) state_next = EMPTY;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    // Entry registers: main drives the outputs, skid catches the overflow entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            case (state)
                EMPTY: if (push) main_q <= incoming;
                ONE: begin
                    if (push && pop) main_q <= incoming;
                    else if (push)   skid_q <= incoming;
                end
                TWO:   if (pop) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    // Saturating count of illegal entries leaving the stage (flush does not clear it).
    always_ff @(posedge clk) begin
        if (rst) illegal_cnt <= '0;
        else if (pop && main_q.illegal && illegal_cnt != 16'hFFFF) illegal_cnt <= illegal_cnt + 16'd1;
    end

endmodule
